multi_timer: RTL and testbench
==============================

# multi_timer

Parametrised multi-channel down-counting timer, successor to the single-channel 8-bit timer. It provides CHANNELS independent timers of WIDTH bits, all driven by one shared programmable prescaler. Each channel runs in one-shot or periodic (auto-reload) mode, can be cancelled, and signals expiry with a single-cycle done pulse. It sits beside the control FSMs that need timeouts, delays and periodic events.

## Interface
- CHANNELS, 4, number of independent timer channels (>=1)
- WIDTH, 16, counter and duration width in bits (>=2)
- PRE_W, 8, prescaler width in bits (>=1)

- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  reset, asynchronous, active-high
- prescale  input  PRE_W  tick divider; one tick every prescale+1 clocks
- duration  input  WIDTH  load value, shared by all channels
- start  input  CHANNELS  start[i] loads duration into channel i and arms it
- stop  input  CHANNELS  stop[i] cancels channel i
- periodic  input  CHANNELS  mode for channel i, sampled with start[i]: 1 = auto-reload, 0 = one-shot
- busy  output  CHANNELS  channel i is armed and counting
- done  output  CHANNELS  one-cycle expiry pulse, registered
- count  output  CHANNELS*WIDTH  current count; channel i at bits [i*WIDTH +: WIDTH]

## Operation
- Reset (async): count=0, busy=0, done=0, reload=0, mode=0, prescaler pre=0. All outputs are 0 on reset.
- Prescaler: free-running PRE_W-bit counter pre.
  - tick=1 on a cycle where pre >= prescale; pre then wraps to 0. Otherwise pre increments.
  - Using >= means lowering prescale mid-run gives a tick on the next cycle, with no long wrap.
  - prescale=0 gives a tick every cycle.
  - tick is shared by all channels and is not re-phased on start.
- Per-channel priority on each edge: stop > start > tick.
- stop[i]: busy=0, count=0, no done pulse. Ignored when the channel is idle.
- start[i] with duration=D>0:
  - count=D, reload=D, mode=periodic[i], busy=1.
  - No decrement on the start edge, even if tick=1.
  - Restarting a busy channel reloads it and does not produce done.
- start[i] with D=0: done[i] pulses on the next cycle and busy stays 0 in either mode.
- On a tick edge, with busy=1 and no stop or start:
  - If count>1: count decrements by 1.
  - If count==1: done[i]=1 for the next cycle.
    - One-shot: count=0 and busy=0.
    - Periodic: count=reload and busy stays 1.
- done is 0 on every cycle not listed above. A periodic channel pulses once every D ticks until stopped.
- Channels are fully independent. Any combination of start and stop bits may be set in the same cycle. Simultaneous starts all load the same duration.
- count never wraps below 0. Arithmetic is unsigned, WIDTH bits, max duration 2^WIDTH-1.
- Asserting rst mid-count aborts all channels immediately, with no done pulse.

## Timing
- prescale=0: done[i] is high during the cycle following the D-th clock edge after the edge that sampled start[i]. That is exactly D cycles of latency, and busy is high for exactly D cycles.
- prescale=P: expiry falls between D*(P+1)-P and D*(P+1) cycles after start, depending on the tick phase.
- stop and expiry on the same edge: stop wins, and done stays 0.
- start and expiry on the same edge: the restart wins, and done stays 0.
- busy falls on the same edge that raises done (one-shot).
- Registered outputs only. No combinational path from inputs to outputs.

## Test plan
- Reset mid-count:
  - Stimulus: prescale=0, start[0] with D=5, one-shot.
  - Required: busy[0] high for exactly 5 cycles; count shows 5,4,3,2,1; done[0] pulses once, 5 cycles after start; busy[0] falls with done[0].
  - Then assert rst while channel 1 counts with D=100. Required: all outputs are 0 immediately, and no done pulse follows.
- Periodic mode:
  - Stimulus: prescale=0, channel 2 periodic with D=3, run for 12 cycles.
  - Required: done[2] pulses every 3 cycles, 4 times; busy[2] stays 1.
  - Then stop[2] on the same edge as a pending expiry. Required: no done pulse, busy=0, count=0.
- Prescaler:
  - Stimulus: prescale=3, start[1] with D=4.
  - Required: done[1] pulses within 13-16 cycles; count changes only on tick edges.
  - Then change prescale from 200 to 1 while pre=150. Required: a tick on the next cycle.
- Boundary values:
  - Stimulus: start[3] with D=0. Required: done[3] pulses next cycle, busy[3] stays 0.
  - Stimulus: D=2^WIDTH-1. Required: expires after 65535 cycles with WIDTH=16.
- Simultaneous events:
  - Stimulus: start all channels at once with D=7. Required: all done bits pulse on the same cycle.
  - Stimulus: restart channel 0 with D=10 when count=1. Required: no done, count=10, expiry 10 cycles later.

Source files
------------

// File: rtl/multi_timer.sv
// ---------------------------------------------------------------------------
// multi_timer
//
// Purpose:
//   CHANNELS independent down-counting timers of WIDTH bits that share one
//   free-running programmable prescaler. Each channel can run one-shot or
//   periodic (auto-reload), can be cancelled, and reports expiry with a
//   registered single-cycle done pulse.
//
// Ports:
//   i_clk       system clock, all state changes on its rising edge
//   i_rst       asynchronous active-high reset
//   i_prescale  tick divider, one tick every i_prescale+1 clocks
//   i_duration  load value shared by all channels
//   i_start     per-channel start: load i_duration and arm
//   i_stop      per-channel cancel
//   i_periodic  per-channel mode sampled with i_start (1 = auto-reload)
//   o_busy      per-channel armed-and-counting flag
//   o_done      per-channel one-cycle expiry pulse
//   o_count     current counts, channel i at [i*WIDTH +: WIDTH]
// ---------------------------------------------------------------------------
module multi_timer #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int PRE_W    = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [PRE_W-1:0]          i_prescale,
  input  logic [WIDTH-1:0]          i_duration,
  input  logic [CHANNELS-1:0]       i_start,
  input  logic [CHANNELS-1:0]       i_stop,
  input  logic [CHANNELS-1:0]       i_periodic,
  output logic [CHANNELS-1:0]       o_busy,
  output logic [CHANNELS-1:0]       o_done,
  output logic [CHANNELS*WIDTH-1:0] o_count
);

  logic [PRE_W-1:0] r_pre;
  logic             w_tick;
  logic             w_zeroDur;

  // Comparing with >= rather than == means that lowering the divider while
  // the prescaler is already past the new value produces a tick on the very
  // next edge instead of waiting for a full PRE_W-bit wrap.
  assign w_tick    = (r_pre >= i_prescale);
  assign w_zeroDur = (i_duration == '0);

  // Shared free-running prescaler. It is never re-phased by a channel start,
  // so the first tick of a freshly started channel depends on its phase.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : gCh
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_mode;
    logic             r_busy;
    logic             r_done;
    logic             w_last;

    assign w_last = (r_count == WIDTH'(1));

    // Channel state. Priority on each edge is stop, then start, then tick.
    // A stop on an idle channel does nothing, so a start in the same cycle
    // still takes effect. A start never decrements on its own edge, and a
    // start or stop that coincides with an expiry suppresses the done pulse
    // because the tick branch is not reached. A zero duration expires
    // immediately without ever becoming busy.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_count  <= '0;
        r_reload <= '0;
        r_mode   <= 1'b0;
        r_busy   <= 1'b0;
        r_done   <= 1'b0;
      end else begin
        r_done <= 1'b0;
        if (i_stop[g] && r_busy) begin
          r_busy  <= 1'b0;
          r_count <= '0;
        end else if (i_start[g]) begin
          r_reload <= i_duration;
          r_mode   <= i_periodic[g];
          if (w_zeroDur) begin
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_count <= i_duration;
            r_busy  <= 1'b1;
          end
        end else if (w_tick && r_busy) begin
          if (w_last) begin
            r_done <= 1'b1;
            if (r_mode) begin
              r_count <= r_reload;
            end else begin
              r_count <= '0;
              r_busy  <= 1'b0;
            end
          end else begin
            r_count <= r_count - WIDTH'(1);
          end
        end
      end
    end

    assign o_count[g*WIDTH +: WIDTH] = r_count;
    assign o_busy[g]                 = r_busy;
    assign o_done[g]                 = r_done;
  end

endmodule

// File: tb/tb_multi_timer.sv
// ---------------------------------------------------------------------------
// tb_multi_timer
//
// Purpose:
//   Self-checking bench for multi_timer with the default parameters
//   (4 channels, 16-bit counters, 8-bit prescaler). Every start that must
//   expire pushes the channel and the cycle of its expected done pulse into a
//   scoreboard queue; a monitor pops an entry for every done pulse it sees.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_multi_timer;

  localparam int CH = 4;
  localparam int W  = 16;
  localparam int PW = 8;

  logic            i_clk;
  logic            i_rst;
  logic [PW-1:0]   i_prescale;
  logic [W-1:0]    i_duration;
  logic [CH-1:0]   i_start;
  logic [CH-1:0]   i_stop;
  logic [CH-1:0]   i_periodic;
  logic [CH-1:0]   o_busy;
  logic [CH-1:0]   o_done;
  logic [CH*W-1:0] o_count;

  typedef struct {
    int     ch;
    longint cyc;
  } expT;

  expT    expQ[$];
  longint cyc;
  int     checkCount;
  int     passCount;
  bit     sbOn;

  multi_timer #(.CHANNELS(CH), .WIDTH(W), .PRE_W(PW)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_prescale (i_prescale),
    .i_duration (i_duration),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_periodic (i_periodic),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_count    (o_count)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Edge counter used to time-stamp starts and expiries.
  initial cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic logic [W-1:0] cnt(input int ch);
    return o_count[ch*W +: W];
  endfunction

  task automatic stepClk(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Insert keeping the queue ordered by cycle, then by channel.
  task automatic pushExp(input int ch, input longint c);
    expT e;
    int  pos;
    e.ch  = ch;
    e.cyc = c;
    pos   = expQ.size();
    for (int k = expQ.size() - 1; k >= 0; k--) begin
      if (expQ[k].cyc > c || (expQ[k].cyc == c && expQ[k].ch > ch)) pos = k;
    end
    expQ.insert(pos, e);
  endtask

  // Drive one start cycle; when track is set, record the expected expiry
  // cycle (D edges after the sampling edge) for every started channel.
  task automatic applyStimulus(input logic [CH-1:0] mask, input logic [W-1:0] dur,
                               input logic [CH-1:0] per, input bit track);
    i_duration = dur;
    i_periodic = per;
    i_start    = mask;
    stepClk(1);
    i_start    = '0;
    if (track) begin
      for (int c = 0; c < CH; c++) begin
        if (mask[c]) pushExp(c, cyc + longint'(dur));
      end
    end
  endtask

  // Scoreboard monitor: every done pulse must match the head of the queue.
  always @(negedge i_clk) begin
    if (sbOn) begin
      for (int i = 0; i < CH; i++) begin
        if (o_done[i]) begin
          if (expQ.size() == 0) begin
            checkOutput($sformatf("unexpectedDone ch%0d", i), 1, 0);
          end else begin
            expT e;
            e = expQ.pop_front();
            checkOutput("doneChannel", i, e.ch);
            checkOutput($sformatf("doneCycle ch%0d", i), cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    longint startCyc;
    longint lat;
    longint chg[8];
    int     nChg;
    bit     found;
    logic [W-1:0] lastCnt;

    checkCount = 0;
    passCount  = 0;
    sbOn       = 1'b1;
    i_rst      = 1'b1;
    i_prescale = '0;
    i_duration = '0;
    i_start    = '0;
    i_stop     = '0;
    i_periodic = '0;

    // Reset state
    stepClk(2);
    checkOutput("resetBusy", o_busy, 0);
    checkOutput("resetDone", o_done, 0);
    checkOutput("resetCount", o_count, 0);
    i_rst = 1'b0;
    stepClk(1);

    // One-shot, D=5, prescale 0
    applyStimulus(4'b0001, 16'd5, 4'b0000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("oneShotCount k%0d", k), cnt(0), 5 - k);
      checkOutput($sformatf("oneShotBusy k%0d", k), o_busy[0], 1);
      stepClk(1);
    end
    checkOutput("oneShotDoneHigh", o_done[0], 1);
    checkOutput("oneShotBusyFell", o_busy[0], 0);
    checkOutput("oneShotCountZero", cnt(0), 0);
    stepClk(1);
    checkOutput("oneShotDoneSingle", o_done[0], 0);

    // Reset while channel 1 counts D=100
    applyStimulus(4'b0010, 16'd100, 4'b0000, 1'b1);
    stepClk(10);
    checkOutput("midCount", cnt(1), 90);
    i_rst = 1'b1;
    #1;
    checkOutput("asyncResetBusy", o_busy, 0);
    checkOutput("asyncResetDone", o_done, 0);
    checkOutput("asyncResetCount", o_count, 0);
    expQ.delete();
    stepClk(2);
    i_rst = 1'b0;
    stepClk(110);

    // Periodic channel 2, D=3, then stop on a pending expiry
    applyStimulus(4'b0100, 16'd3, 4'b0100, 1'b1);
    pushExp(2, cyc + 6);
    pushExp(2, cyc + 9);
    pushExp(2, cyc + 12);
    for (int k = 0; k < 12; k++) begin
      stepClk(1);
      checkOutput($sformatf("periodicBusy k%0d", k), o_busy[2], 1);
    end
    stepClk(2);
    checkOutput("periodicPreStopCount", cnt(2), 1);
    i_stop = 4'b0100;
    stepClk(1);
    i_stop = '0;
    checkOutput("stopDone", o_done[2], 0);
    checkOutput("stopBusy", o_busy[2], 0);
    checkOutput("stopCount", cnt(2), 0);
    stepClk(3);

    // Prescale 3, D=4 on channel 1: latency window and tick-only changes
    sbOn = 1'b0;
    i_prescale = 8'd3;
    applyStimulus(4'b0010, 16'd4, 4'b0000, 1'b0);
    startCyc = cyc;
    lastCnt  = cnt(1);
    nChg     = 0;
    found    = 1'b0;
    lat      = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      stepClk(1);
      if (cnt(1) != lastCnt) begin
        if (nChg < 8) chg[nChg] = cyc;
        nChg++;
        lastCnt = cnt(1);
      end
      if (o_done[1]) begin
        found = 1'b1;
        lat   = cyc - startCyc;
      end
    end
    checkOutput("preDoneSeen", found, 1);
    checkOutput("preLatencyInWindow", (lat >= 13 && lat <= 16), 1);
    checkOutput("preCountChanges", nChg, 4);
    if (nChg == 4) begin
      for (int j = 1; j < 4; j++) begin
        checkOutput($sformatf("preTickSpacing j%0d", j), chg[j] - chg[j-1], 4);
      end
    end

    // Lower prescale from 200 to 1 while the prescaler sits at 150
    i_prescale = 8'd200;
    i_rst = 1'b1;
    stepClk(2);
    i_rst = 1'b0;
    applyStimulus(4'b0001, 16'd2, 4'b0000, 1'b0);
    stepClk(149);
    checkOutput("slowNoTick", cnt(0), 2);
    i_prescale = 8'd1;
    stepClk(1);
    checkOutput("prescaleDropTick", cnt(0), 1);
    i_rst = 1'b1;
    i_prescale = '0;
    stepClk(2);
    i_rst = 1'b0;
    expQ.delete();
    sbOn = 1'b1;
    stepClk(1);

    // Zero duration on channel 3
    applyStimulus(4'b1000, 16'd0, 4'b0000, 1'b1);
    checkOutput("zeroDurDone", o_done[3], 1);
    checkOutput("zeroDurBusy", o_busy[3], 0);
    stepClk(1);
    checkOutput("zeroDurDoneSingle", o_done[3], 0);

    // All channels started together, D=7
    applyStimulus(4'b1111, 16'd7, 4'b0000, 1'b1);
    stepClk(6);
    checkOutput("simulNotEarly", o_done, 0);
    stepClk(1);
    checkOutput("simulDoneAll", o_done, 15);
    checkOutput("simulBusyAll", o_busy, 0);
    stepClk(2);

    // Restart channel 0 with D=10 on the edge it would expire
    applyStimulus(4'b0001, 16'd4, 4'b0000, 1'b0);
    stepClk(3);
    checkOutput("restartPreCount", cnt(0), 1);
    applyStimulus(4'b0001, 16'd10, 4'b0000, 1'b1);
    checkOutput("restartCount", cnt(0), 10);
    checkOutput("restartNoDone", o_done[0], 0);
    stepClk(9);
    checkOutput("restartNotEarly", o_done[0], 0);
    stepClk(1);
    checkOutput("restartDone", o_done[0], 1);
    stepClk(2);

    // Maximum duration on channel 1
    applyStimulus(4'b0010, 16'hFFFF, 4'b0000, 1'b1);
    stepClk(65534);
    checkOutput("maxNotEarly", o_done[1], 0);
    checkOutput("maxLastCount", cnt(1), 1);
    stepClk(1);
    checkOutput("maxDone", o_done[1], 1);
    stepClk(3);

    checkOutput("scoreboardDrained", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
